// File: rtl/burp_seq_ctrl.sv
// ---------------------------------------------------------------------------
// burp_seq_ctrl
// Fetch/execute sequencer for the BURP 8-bit core. Fetches {opcode, operand}
// bytes from a combinational program ROM, owns the program counter and the
// stack pointer, and issues one-cycle strobes to the ALU/regfile, carry flag
// and stack RAM, plus held request/valid handshakes for the IN/OUT ports.
// Exactly one instruction is in flight at a time.
//
// Optional feature (compile-time macro BURP_SINGLE_STEP_EN):
//   defined   -> extra input 'step'; FETCH waits for step=1 before loading
//                the next instruction.
//   undefined -> no 'step' port, FETCH never stalls.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   step                  single-step enable (only with BURP_SINGLE_STEP_EN)
//   rom_addr / rom_data   program ROM address (= PC) and instruction byte
//   lbl_idx / lbl_addr    jump label index (operand) and its absolute target
//   carry                 current ALU carry flag (JC condition)
//   alu_en/alu_op/alu_arg ALU execute strobe, opcode and operand (mirror IR)
//   carry_set/carry_clr   SC / CC strobes
//   stk_addr/stk_we/stk_re stack RAM address, push write, pop read strobes
//   in_req / in_valid     IN handshake (request held until in_valid)
//   out_valid / out_ready OUT handshake (valid held until out_ready)
//   stk_err               sticky stack overflow/underflow flag
//   state_o               current FSM state (debug)
// ---------------------------------------------------------------------------
module burp_seq_ctrl #(
  parameter int         STK_DEPTH = 16,
  parameter logic [7:0] RESET_PC  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef BURP_SINGLE_STEP_EN
  input  logic       step,
`endif
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [3:0] lbl_idx,
  input  logic [7:0] lbl_addr,
  input  logic       carry,
  output logic       alu_en,
  output logic [3:0] alu_op,
  output logic [3:0] alu_arg,
  output logic       carry_set,
  output logic       carry_clr,
  output logic [7:0] stk_addr,
  output logic       stk_we,
  output logic       stk_re,
  output logic       in_req,
  input  logic       in_valid,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       stk_err,
  output logic [2:0] state_o
);

  // sp needs one bit more than the address so that "full" (sp == STK_DEPTH)
  // is distinguishable from "empty" (sp == 0).
  localparam int SPW = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
  localparam logic [SPW:0] SP_FULL = (SPW + 1)'(STK_DEPTH);
  localparam logic [SPW:0] SP_ONE  = (SPW + 1)'(1);
  localparam logic [SPW:0] SP_ZERO = '0;

  localparam logic [2:0] S_FETCH    = 3'd0;
  localparam logic [2:0] S_EXEC     = 3'd1;
  localparam logic [2:0] S_POP_WB   = 3'd2;
  localparam logic [2:0] S_WAIT_IN  = 3'd3;
  localparam logic [2:0] S_WAIT_OUT = 3'd4;
  localparam logic [2:0] S_ERR      = 3'd5;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_OUT  = 4'h1;
  localparam logic [3:0] OP_IN   = 4'h2;
  localparam logic [3:0] OP_POP  = 4'h3;
  localparam logic [3:0] OP_PUSH = 4'h4;
  localparam logic [3:0] OP_CC   = 4'h5;
  localparam logic [3:0] OP_SC   = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_JC   = 4'hF;

  logic [2:0]   state_q, state_d;
  logic [7:0]   pc_q, pc_d;
  logic [SPW:0] sp_q, sp_d;
  logic [7:0]   ir_q, ir_d;
  logic         in_req_q, in_req_d;
  logic         out_valid_q, out_valid_d;
  logic         stk_err_q, stk_err_d;
  logic [SPW:0] stk_ptr;
  logic         fetch_go;

`ifdef BURP_SINGLE_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    sp_d        = sp_q;
    ir_d        = ir_q;
    in_req_d    = in_req_q;
    out_valid_d = out_valid_q;
    stk_err_d   = stk_err_q;
    stk_ptr     = sp_q;
    alu_en      = 1'b0;
    carry_set   = 1'b0;
    carry_clr   = 1'b0;
    stk_we      = 1'b0;
    stk_re      = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (fetch_go) begin
          ir_d    = rom_data;
          pc_d    = pc_q + 8'd1;          // natural 8-bit wrap FF -> 00
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (ir_q[7:4])
          OP_NOP: ;
          OP_OUT: begin
            out_valid_d = 1'b1;
            state_d     = S_WAIT_OUT;
          end
          OP_IN: begin
            in_req_d = 1'b1;
            state_d  = S_WAIT_IN;
          end
          OP_POP: begin
            if (sp_q == SP_ZERO) begin
              stk_err_d = 1'b1;
              state_d   = S_ERR;
            end else begin
              // Top of stack lives one below sp.
              stk_ptr = sp_q - SP_ONE;
              stk_re  = 1'b1;
              sp_d    = sp_q - SP_ONE;
              state_d = S_POP_WB;
            end
          end
          OP_PUSH: begin
            if (sp_q == SP_FULL) begin
              stk_err_d = 1'b1;
              state_d   = S_ERR;
            end else begin
              stk_we = 1'b1;
              sp_d   = sp_q + SP_ONE;
            end
          end
          OP_CC:  carry_clr = 1'b1;
          OP_SC:  carry_set = 1'b1;
          OP_JMP: pc_d = lbl_addr;
          OP_JC: begin
            if (carry) pc_d = lbl_addr;
          end
          default: alu_en = 1'b1;         // opcodes 7..D go to the ALU
        endcase
      end

      // Regfile captures the popped word this cycle using the held alu_op.
      S_POP_WB: state_d = S_FETCH;

      S_WAIT_IN: begin
        if (in_valid) begin
          alu_en   = 1'b1;
          in_req_d = 1'b0;
          state_d  = S_FETCH;
        end
      end

      S_WAIT_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_FETCH;
        end
      end

      S_ERR: ;                            // terminal until reset

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      sp_q        <= SP_ZERO;
      ir_q        <= 8'h00;
      in_req_q    <= 1'b0;
      out_valid_q <= 1'b0;
      stk_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      sp_q        <= sp_d;
      ir_q        <= ir_d;
      in_req_q    <= in_req_d;
      out_valid_q <= out_valid_d;
      stk_err_q   <= stk_err_d;
    end
  end

  assign rom_addr  = pc_q;
  assign lbl_idx   = ir_q[3:0];
  assign alu_op    = ir_q[7:4];
  assign alu_arg   = ir_q[3:0];
  assign stk_addr  = 8'(stk_ptr);
  assign in_req    = in_req_q;
  assign out_valid = out_valid_q;
  assign stk_err   = stk_err_q;
  assign state_o   = state_q;

endmodule
